// File: rtl/tex_env_config_loader.sv
// Command-stream loader for the tex-env mixer's func/envColor registers.
// A new value is only applied once every pixel already inside the mixer has drained out.
module tex_env_config_loader #(
    parameter  int SUB_PIXEL_WIDTH = 8,
    parameter  int CMD_WIDTH       = 32,
    parameter  int PIPELINE_DEPTH  = 2,
    localparam int PIXEL_WIDTH     = 4 * SUB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   s_cmd_tvalid,
    output logic                   s_cmd_tready,
    input  logic [CMD_WIDTH-1:0]   s_cmd_tdata,
    input  logic                   pix_valid_in,
    output logic                   pix_hold,
    output logic [2:0]             func,
    output logic [PIXEL_WIDTH-1:0] envColor,
    output logic                   cfg_busy,
    output logic                   cfg_unknown
);

    localparam int CNT_W = $clog2(PIPELINE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPELINE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN,
        APPLY
    } state_t;

    state_t                 state;
    logic [3:0]             reg_id;
    logic [PIXEL_WIDTH-1:0] shadow;
    logic [CNT_W-1:0]       drain_cnt;
    logic                   payload_ok;

    // Func values 6 and 7 have no meaning in the mixer and are rejected like an unknown id.
    assign payload_ok = (reg_id == 4'h1) ||
                        ((reg_id == 4'h0) && (s_cmd_tdata[2:0] <= 3'd5));

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            drain_cnt <= '0;
        end else if (pix_valid_in) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            reg_id       <= '0;
            shadow       <= '0;
            s_cmd_tready <= 1'b0;
            pix_hold     <= 1'b0;
            cfg_busy     <= 1'b0;
            cfg_unknown  <= 1'b0;
            func         <= 3'd0;
            envColor     <= '0;
        end else begin
            cfg_unknown <= 1'b0;
            case (state)
                IDLE: begin
                    s_cmd_tready <= 1'b1;
                    if (s_cmd_tvalid && s_cmd_tready) begin
                        reg_id   <= s_cmd_tdata[3:0];
                        cfg_busy <= 1'b1;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (s_cmd_tvalid && s_cmd_tready) begin
                        shadow <= s_cmd_tdata[PIXEL_WIDTH-1:0];
                        if (payload_ok) begin
                            pix_hold     <= 1'b1;
                            s_cmd_tready <= 1'b0;
                            state        <= DRAIN;
                        end else begin
                            cfg_busy    <= 1'b0;
                            cfg_unknown <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if ((drain_cnt == '0) && !pix_valid_in) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    if (reg_id == 4'h1) begin
                        envColor <= shadow;
                    end else begin
                        func <= shadow[2:0];
                    end
                    pix_hold     <= 1'b0;
                    cfg_busy     <= 1'b0;
                    s_cmd_tready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tex_env_config_loader.sv
// Directed bench for tex_env_config_loader: hand-computed cycle-by-cycle expectations.
module tb_tex_env_config_loader;

    logic        aclk;
    logic        resetn;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic [31:0] s_cmd_tdata;
    logic        pix_valid_in;
    logic        pix_hold;
    logic [2:0]  func;
    logic [31:0] envColor;
    logic        cfg_busy;
    logic        cfg_unknown;

    int checks = 0;
    int passes = 0;

    tex_env_config_loader dut (
        .aclk         (aclk),
        .resetn       (resetn),
        .s_cmd_tvalid (s_cmd_tvalid),
        .s_cmd_tready (s_cmd_tready),
        .s_cmd_tdata  (s_cmd_tdata),
        .pix_valid_in (pix_valid_in),
        .pix_hold     (pix_hold),
        .func         (func),
        .envColor     (envColor),
        .cfg_busy     (cfg_busy),
        .cfg_unknown  (cfg_unknown)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic pix);
        s_cmd_tvalid = valid;
        s_cmd_tdata  = data;
        pix_valid_in = pix;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        resetn = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        #2 resetn = 1'b0;
        step();
        step();
        checkOutput("rst_func", 32'(func), 32'd0);
        checkOutput("rst_color", envColor, 32'h0);
        checkOutput("rst_hold", 32'(pix_hold), 32'd0);
        checkOutput("rst_busy", 32'(cfg_busy), 32'd0);
        checkOutput("rst_unknown", 32'(cfg_unknown), 32'd0);
        checkOutput("rst_tready", 32'(s_cmd_tready), 32'd0);
        resetn = 1'b1;
        checkOutput("tready_at_release", 32'(s_cmd_tready), 32'd0);
        step();
        checkOutput("tready_after_release", 32'(s_cmd_tready), 32'd1);

        // FUNC = MODULATE with an empty pipe
        applyStimulus(1'b1, 32'h0, 1'b0);
        step();
        checkOutput("f1_busy_payload", 32'(cfg_busy), 32'd1);
        applyStimulus(1'b1, 32'h2, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("f1_hold_m1", 32'(pix_hold), 32'd1);
        checkOutput("f1_tready_m1", 32'(s_cmd_tready), 32'd0);
        step();
        checkOutput("f1_hold_m2", 32'(pix_hold), 32'd1);
        checkOutput("f1_func_m2", 32'(func), 32'd0);
        step();
        checkOutput("f1_func_m3", 32'(func), 32'd2);
        checkOutput("f1_hold_m3", 32'(pix_hold), 32'd0);
        checkOutput("f1_busy_m3", 32'(cfg_busy), 32'd0);
        checkOutput("f1_color_m3", envColor, 32'h0);
        checkOutput("f1_tready_m3", 32'(s_cmd_tready), 32'd1);

        // COLOR with a pixel entering on the payload cycle
        applyStimulus(1'b1, 32'h1, 1'b0);
        step();
        applyStimulus(1'b1, 32'h11223344, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("c_hold_m1", 32'(pix_hold), 32'd1);
        step();
        checkOutput("c_hold_m2", 32'(pix_hold), 32'd1);
        step();
        checkOutput("c_hold_m3", 32'(pix_hold), 32'd1);
        checkOutput("c_color_m3", envColor, 32'h0);
        step();
        checkOutput("c_hold_m4", 32'(pix_hold), 32'd1);
        checkOutput("c_color_m4", envColor, 32'h0);
        step();
        checkOutput("c_color_m5", envColor, 32'h11223344);
        checkOutput("c_hold_m5", 32'(pix_hold), 32'd0);
        checkOutput("c_func_m5", 32'(func), 32'd2);

        // Unknown id 0x7 is consumed and flagged
        applyStimulus(1'b1, 32'h7, 1'b0);
        step();
        checkOutput("u_tready_payload", 32'(s_cmd_tready), 32'd1);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("u_unknown_pulse", 32'(cfg_unknown), 32'd1);
        checkOutput("u_hold", 32'(pix_hold), 32'd0);
        checkOutput("u_busy", 32'(cfg_busy), 32'd0);
        step();
        checkOutput("u_unknown_end", 32'(cfg_unknown), 32'd0);
        checkOutput("u_hold_after", 32'(pix_hold), 32'd0);
        checkOutput("u_func", 32'(func), 32'd2);
        checkOutput("u_color", envColor, 32'h11223344);

        // Illegal func value 6
        applyStimulus(1'b1, 32'h0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h6, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("i_unknown_pulse", 32'(cfg_unknown), 32'd1);
        checkOutput("i_hold", 32'(pix_hold), 32'd0);
        step();
        checkOutput("i_unknown_end", 32'(cfg_unknown), 32'd0);
        checkOutput("i_func", 32'(func), 32'd2);

        // Header, five idle cycles, then payload 0x4
        applyStimulus(1'b1, 32'h0, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("g_busy_gap%0d", i), 32'(cfg_busy), 32'd1);
            step();
        end
        applyStimulus(1'b1, 32'h4, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("g_tready_drain", 32'(s_cmd_tready), 32'd0);
        checkOutput("g_busy_drain", 32'(cfg_busy), 32'd1);
        step();
        checkOutput("g_tready_apply", 32'(s_cmd_tready), 32'd0);
        checkOutput("g_func_apply", 32'(func), 32'd2);
        step();
        checkOutput("g_func_done", 32'(func), 32'd4);
        checkOutput("g_busy_done", 32'(cfg_busy), 32'd0);
        checkOutput("g_tready_done", 32'(s_cmd_tready), 32'd1);

        // Reset asserted during DRAIN
        applyStimulus(1'b1, 32'h1, 1'b0);
        step();
        applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("r_hold_pre", 32'(pix_hold), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("r_hold", 32'(pix_hold), 32'd0);
        checkOutput("r_busy", 32'(cfg_busy), 32'd0);
        checkOutput("r_func", 32'(func), 32'd0);
        checkOutput("r_color", envColor, 32'h0);
        checkOutput("r_tready", 32'(s_cmd_tready), 32'd0);
        step();
        resetn = 1'b1;
        step();
        checkOutput("r_tready_back", 32'(s_cmd_tready), 32'd1);
        applyStimulus(1'b1, 32'h0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h5, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checkOutput("r_func_apply", 32'(func), 32'd0);
        step();
        checkOutput("r_func_new", 32'(func), 32'd5);
        checkOutput("r_color_kept", envColor, 32'h0);
        checkOutput("r_hold_new", 32'(pix_hold), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
